// File: rtl/core_clk_gen.sv
// Core clock-enable generator: waits for PLL lock, holds it for LOCK_HOLD cycles,
// releases the core reset after RST_CE enable pulses, then produces core_ce from a
// phase accumulator and phi_ce on every PHI_DIV-th core_ce.
//
//   state     | meaning
//   WAIT_LOCK | PLL not locked; core held in reset, enables idle
//   HOLD      | counting consecutive lock cycles before starting the core
//   RST_OUT   | accumulator running, core_rst still asserted for RST_CE pulses
//   RUN       | normal operation, core_rst released
//   PAUSED    | debug stall; accumulator frozen, enables idle
module core_clk_gen #(
   parameter int          ACC_W     = 24,
   parameter int unsigned INC       = 5864062,
   parameter int          PHI_DIV   = 4,
   parameter int          LOCK_HOLD = 1024,
   parameter int          RST_CE    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_lock,
   input  logic             pause,
   input  logic             inc_load,
   input  logic [ACC_W-1:0] inc_val,
   output logic             core_ce,
   output logic             phi_ce,
   output logic             core_rst,
   output logic             running
);

   localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
   localparam int PH_W   = $clog2(PHI_DIV + 1);
   localparam int PC_W   = $clog2(RST_CE + 1);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      HOLD      = 3'd1,
      RST_OUT   = 3'd2,
      RUN       = 3'd3,
      PAUSED    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    inc_q, inc_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [PC_W-1:0]     pcnt_q, pcnt_d;
   logic                core_ce_q, core_ce_d;
   logic                phi_ce_q, phi_ce_d;
   logic                core_rst_q;
   logic                running_q;
   logic [ACC_W:0]      sum;
   logic                advance;

   assign sum = {1'b0, acc_q} + {1'b0, inc_q};

   // Next-state and datapath: lock loss outranks every other transition.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      inc_d     = inc_load ? inc_val : inc_q;
      hold_d    = hold_q;
      phase_d   = phase_q;
      pcnt_d    = pcnt_q;
      core_ce_d = 1'b0;
      phi_ce_d  = 1'b0;
      advance   = 1'b0;
      if (state_q != WAIT_LOCK && !pll_lock) begin
         state_d = WAIT_LOCK;
         acc_d   = '0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               if (pll_lock) begin
                  state_d = HOLD;
                  hold_d  = '0;
               end
            end
            HOLD: begin
               if (hold_q == HOLD_W'(LOCK_HOLD - 1)) begin
                  state_d = RST_OUT;
                  acc_d   = '0;
                  phase_d = '0;
                  pcnt_d  = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            RST_OUT: begin
               advance = 1'b1;
               // The pulse being output now is counted; the last one releases the core.
               if (core_ce_q) begin
                  if (pcnt_q == PC_W'(RST_CE - 1)) state_d = RUN;
                  else                             pcnt_d  = pcnt_q + 1'b1;
               end
            end
            RUN: begin
               advance = 1'b1;
               if (pause) state_d = PAUSED;
            end
            PAUSED: begin
               if (!pause) state_d = RUN;
            end
            default: state_d = WAIT_LOCK;
         endcase
      end
      if (advance) begin
         acc_d     = sum[ACC_W-1:0];
         core_ce_d = sum[ACC_W];
         if (sum[ACC_W]) begin
            phi_ce_d = (phase_q == PH_W'(PHI_DIV - 1));
            phase_d  = phi_ce_d ? '0 : phase_q + 1'b1;
         end
      end
   end

   // State and registered outputs; core_rst/running follow the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT_LOCK;
         acc_q      <= '0;
         inc_q      <= ACC_W'(INC);
         hold_q     <= '0;
         phase_q    <= '0;
         pcnt_q     <= '0;
         core_ce_q  <= 1'b0;
         phi_ce_q   <= 1'b0;
         core_rst_q <= 1'b1;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         inc_q      <= inc_d;
         hold_q     <= hold_d;
         phase_q    <= phase_d;
         pcnt_q     <= pcnt_d;
         core_ce_q  <= core_ce_d;
         phi_ce_q   <= phi_ce_d;
         core_rst_q <= (state_d == WAIT_LOCK) || (state_d == HOLD) || (state_d == RST_OUT);
         running_q  <= (state_d == RUN);
      end
   end

   assign core_ce  = core_ce_q;
   assign phi_ce   = phi_ce_q;
   assign core_rst = core_rst_q;
   assign running  = running_q;

endmodule

// File: tb/tb_core_clk_gen.sv
// Directed bench for core_clk_gen with a small-config behavioural model checked every cycle.
module tb_core_clk_gen;

   localparam int ACC_W     = 4;
   localparam int INC       = 4;
   localparam int PHI_DIV   = 4;
   localparam int LOCK_HOLD = 8;
   localparam int RST_CE    = 2;
   localparam int MOD       = 1 << ACC_W;

   localparam int M_WAIT = 0, M_HOLD = 1, M_RSTO = 2, M_RUN = 3, M_PAUSE = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pll_lock = 1'b0;
   logic             pause = 1'b0;
   logic             inc_load = 1'b0;
   logic [ACC_W-1:0] inc_val = '0;
   logic             core_ce, phi_ce, core_rst, running;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   core_clk_gen #(
      .ACC_W(ACC_W), .INC(INC), .PHI_DIV(PHI_DIV), .LOCK_HOLD(LOCK_HOLD), .RST_CE(RST_CE)
   ) dut (
      .clk(clk), .rst(rst), .pll_lock(pll_lock), .pause(pause),
      .inc_load(inc_load), .inc_val(inc_val),
      .core_ce(core_ce), .phi_ce(phi_ce), .core_rst(core_rst), .running(running)
   );

   // Behavioural model: mode, lock-cycle count, accumulator value, pulses since start-up.
   int m_mode = M_WAIT, m_hold = 0, m_acc = 0, m_inc = INC, m_pulses = 0;
   bit m_ce = 0, m_phi = 0, m_rst = 1, m_run = 0;

   always @(posedge clk) begin
      int nxt_inc;
      int s;
      bit add;
      if (rst) begin
         m_mode = M_WAIT; m_acc = 0; m_inc = INC; m_ce = 0; m_phi = 0;
         m_pulses = 0; m_hold = 0;
      end else begin
         nxt_inc = inc_load ? int'(inc_val) : m_inc;
         add = 0;
         if (m_mode != M_WAIT && !pll_lock) begin
            m_mode = M_WAIT;
            m_acc  = 0;
         end else begin
            case (m_mode)
               M_WAIT:  if (pll_lock) begin m_mode = M_HOLD; m_hold = 0; end
               M_HOLD: begin
                  m_hold++;
                  if (m_hold == LOCK_HOLD) begin m_mode = M_RSTO; m_acc = 0; m_pulses = 0; end
               end
               M_RSTO: begin
                  if (m_ce && m_pulses == RST_CE) m_mode = M_RUN;
                  add = 1;
               end
               M_RUN: begin
                  add = 1;
                  if (pause) m_mode = M_PAUSE;
               end
               M_PAUSE: if (!pause) m_mode = M_RUN;
               default: m_mode = M_WAIT;
            endcase
         end
         m_ce = 0;
         m_phi = 0;
         if (add) begin
            s = m_acc + m_inc;
            if (s >= MOD) begin
               m_ce = 1;
               m_pulses++;
               m_phi = (m_pulses % PHI_DIV) == 0;
            end
            m_acc = s % MOD;
         end
         m_inc = nxt_inc;
      end
      m_rst = (m_mode == M_WAIT) || (m_mode == M_HOLD) || (m_mode == M_RSTO);
      m_run = (m_mode == M_RUN);
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         n_tests++;
         if ({core_ce, phi_ce, core_rst, running} !== {m_ce, m_phi, m_rst, m_run}) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t ce/phi/rst/run actual=%b required=%b",
                     $time, {core_ce, phi_ce, core_rst, running}, {m_ce, m_phi, m_rst, m_run});
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Negedges until core_ce is seen; bounded so a dead DUT returns 60 and fails the caller.
   task automatic find_ce(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!core_ce && n < 60);
   endtask

   task automatic load_inc(input int v);
      inc_load = 1'b1;
      inc_val  = ACC_W'(v);
      @(negedge clk);
      inc_load = 1'b0;
   endtask

   initial begin
      int n, cnt, adj, hi;
      bit prev;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_outputs", {core_ce, phi_ce, core_rst, running}, 4'b0010);

      // Start-up: 8 HOLD cycles, core_ce every 4th cycle, core_rst released after 2nd pulse.
      rst = 1'b0; pll_lock = 1'b1;
      find_ce(n);  check("first_ce_latency", n, 13);
      find_ce(n);  check("second_ce_gap", n, 4);
      check("rst_held_at_2nd_ce", core_rst, 1);
      @(negedge clk);
      check("rst_release", {core_rst, running}, 2'b01);
      find_ce(n);  check("third_ce_gap", n, 3);
      find_ce(n);  check("fourth_ce_gap", n, 4);
      check("phi_on_4th", phi_ce, 1);

      // Increment 3: three pulses per 16 cycles, never adjacent.
      load_inc(3);
      cnt = 0; adj = 0; prev = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (core_ce) begin cnt++; if (prev) adj++; end
         prev = core_ce;
      end
      check("inc3_pulses", cnt, 3);
      check("inc3_adjacent", adj, 0);

      // Pause for 10 cycles, then resume.
      pause = 1'b1;
      cnt = 0; hi = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0 && core_ce) cnt++;
         if (running) hi++;
      end
      check("pause_no_ce", cnt, 0);
      check("pause_running", hi, 0);
      pause = 1'b0;
      hi = 0;
      repeat (6) begin @(negedge clk); if (core_rst) hi++; end
      check("rst_after_pause", hi, 0);

      // Spacing 4 with increment 4, then 2 with increment 8, then none with 0.
      load_inc(4);
      find_ce(n);
      find_ce(n);  check("spacing_inc4", n, 4);
      load_inc(8);
      find_ce(n);
      find_ce(n);  check("spacing_inc8", n, 2);
      inc_load = 1'b1; inc_val = '0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         inc_load = 1'b0;
         if (i > 0 && core_ce) cnt++;
      end
      check("inc0_no_ce", cnt, 0);
      check("inc0_running", running, 1);

      // Lock loss in RUN, then full restart.
      load_inc(4);
      pll_lock = 1'b0;
      @(negedge clk);
      check("lockloss_outputs", {core_ce, phi_ce, core_rst, running}, 4'b0010);
      pll_lock = 1'b1;
      find_ce(n);  check("relock_latency", n, 13);

      // Lock dropped after 5 HOLD cycles restarts the hold count.
      rst = 1'b1; pll_lock = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pll_lock = 1'b1;
      repeat (5) @(negedge clk);
      pll_lock = 1'b0;
      @(negedge clk);
      check("hold_drop_rst", core_rst, 1);
      pll_lock = 1'b1;
      find_ce(n);  check("hold_restart", n, 13);

      // Reset during RST_OUT with increment 8 loaded; increment must revert.
      load_inc(8);
      pll_lock = 1'b0;
      @(negedge clk);
      pll_lock = 1'b1;
      repeat (10) @(negedge clk);
      check("in_rstout_rst", core_rst, 1);
      rst = 1'b1; inc_load = 1'b1; inc_val = 4'd8;
      @(negedge clk);
      check("rst_in_rstout", {core_ce, phi_ce, core_rst, running}, 4'b0010);
      rst = 1'b0; inc_load = 1'b0;
      find_ce(n);  check("inc_revert_rstout", n, 13);

      // Reset while PAUSED.
      repeat (8) @(negedge clk);
      load_inc(8);
      pause = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_paused", {core_ce, phi_ce, core_rst, running}, 4'b0010);
      rst = 1'b0; pause = 1'b0;
      find_ce(n);  check("inc_revert_paused", n, 13);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/core_clk_gen.md
CORE_CLK_GEN -- requirements
Module: core_clk_gen

Interface
REQ-001 Parameter ACC_W, default 24: phase-accumulator width in bits; legal range 4..32.
REQ-002 Parameter INC, default 5864062: reset-time increment; gives 4.194304 MHz from a 12 MHz clk; legal range 0..2^ACC_W-1.
REQ-003 Parameter PHI_DIV, default 4: core_ce pulses per phi_ce pulse; legal range 1..16.
REQ-004 Parameter LOCK_HOLD, default 1024: consecutive clk cycles with pll_lock=1 required before core reset release begins; legal range >=1.
REQ-005 Parameter RST_CE, default 16: core_ce pulses issued while core_rst is held; legal range >=1.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 pll_lock  input  1  PLL lock indicator; already synchronised to clk.
REQ-009 pause  input  1  debug stall request; level-sensitive.
REQ-010 inc_load  input  1  one-cycle strobe; loads inc_val into the increment register.
REQ-011 inc_val  input  ACC_W  new increment value.
REQ-012 core_ce  output  1  core clock enable; one-cycle pulse.
REQ-013 phi_ce  output  1  phi clock enable; one-cycle pulse, only ever coincident with core_ce.
REQ-014 core_rst  output  1  synchronous reset to the core, active high.
REQ-015 running  output  1  high when the block is in state RUN.

Function
REQ-016 State machine states: WAIT_LOCK, HOLD, RST_OUT, RUN, PAUSED.
REQ-017 WAIT_LOCK -> HOLD when pll_lock=1; the hold counter is cleared on that transition.
REQ-018 In HOLD, the hold counter increments each cycle while pll_lock=1. After LOCK_HOLD consecutive lock cycles -> RST_OUT.
REQ-019 Entering RST_OUT clears the accumulator, the phi phase counter and the RST_CE pulse counter.
REQ-020 RST_OUT -> RUN on the cycle the RST_CE-th core_ce pulse is output; core_rst is 0 from the following cycle.
REQ-021 RUN -> PAUSED when pause=1; PAUSED -> RUN when pause=0. Each transition takes effect one cycle after the pause change.
REQ-022 Accumulator behaviour:
  - Advances only in RST_OUT and RUN: {carry, acc} <= acc + inc_reg, ACC_W+1 bit sum, wraps modulo 2^ACC_W.
  - core_ce <= carry, registered: one cycle latency from the add.
  - Average core_ce rate = f_clk * inc_reg / 2^ACC_W.
REQ-023 In WAIT_LOCK, HOLD and PAUSED: accumulator frozen, core_ce=0, phi_ce=0. A carry computed in the cycle pause is sampled is still output.
REQ-024 Phi phase counter:
  - Counts core_ce pulses modulo PHI_DIV.
  - phi_ce=1 exactly on the core_ce pulse where the counter equals PHI_DIV-1.
  - With PHI_DIV=1, phi_ce equals core_ce.
REQ-025 Increment register:
  - inc_load=1 loads inc_val into inc_reg in any state; the new value is used by the next add.
  - inc_val=0 is legal and yields no core_ce.
  - Accumulator contents are preserved across a load; no phase reset.
REQ-026 Lock loss: pll_lock=0 in HOLD, RST_OUT, RUN or PAUSED -> WAIT_LOCK on the next cycle, with:
  - core_rst=1, core_ce=0, phi_ce=0;
  - accumulator cleared.
  - This takes priority over pause and over the RST_CE terminal count.
REQ-027 core_rst=1 in WAIT_LOCK, HOLD and RST_OUT; 0 in RUN and PAUSED.
REQ-028 running=1 only in RUN.
REQ-029 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-030 rst=1 gives, on the next clock edge:
  - state WAIT_LOCK; core_ce=0, phi_ce=0, core_rst=1, running=0;
  - accumulator, hold counter, pulse counter and phase counter = 0;
  - inc_reg=INC.
REQ-031 rst asserted mid-operation (any state) produces the same result as REQ-030 and overrides inc_load, pause and pll_lock in that cycle.

Verification
REQ-032 ACC_W=4, INC=4, PHI_DIV=4, LOCK_HOLD=8, RST_CE=2; pll_lock=1 from reset:
  - 8 HOLD cycles, then core_ce every 4th cycle;
  - core_rst falls one cycle after the 2nd core_ce;
  - phi_ce on every 4th core_ce.
REQ-033 Same config, INC=3: exactly 3 core_ce pulses per 16 RUN cycles, with no two pulses adjacent.
REQ-034 pll_lock dropped for 1 cycle in mid-HOLD (after cycle 5): HOLD restarts and requires 8 further lock cycles. pll_lock dropped in RUN: core_rst=1 and core_ce=0 next cycle, then the full sequence repeats.
REQ-035 pause held 10 cycles in RUN:
  - running=0, no core_ce, accumulator unchanged;
  - on release, the pulse spacing resumes from the saved phase, and core_rst stays 0.
REQ-036 inc_load with inc_val=8 mid-RUN (INC=4, ACC_W=4): core_ce spacing changes from 4 to 2 cycles starting with the next add. inc_val=0: core_ce stops, running stays 1.
REQ-037 rst pulsed in RST_OUT and in PAUSED: all outputs match REQ-030 on the next cycle, and inc_reg reverts to INC.
